rtc_bus_arbiter: RTL

Sequences multiplexed address/data bus cycles to the external real-time-clock chip (active-low CS, RD, WR; A_D selects address vs. data phase) and shares that single bus between two requesters. Port 0 carries configuration writes from the setup logic; port 1 carries periodic time-register reads from the display poller. The block sits between the requesters and the RTC pins, and is the only driver of the RTC strobes and the AD pad enable.

---
 rtl/rtc_bus_arbiter.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/rtc_bus_arbiter.sv
// Two-port arbiter and bus-cycle sequencer for a multiplexed-AD real-time-clock chip.
// Define RTC_ARB_RR_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module rtc_bus_arbiter #(
  parameter int unsigned PULSE_CYC = 10,
  parameter int unsigned GAP_CYC   = 10
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       req0,
  input  logic       req1,
  input  logic       rw0,
  input  logic       rw1,
  input  logic [7:0] addr0,
  input  logic [7:0] addr1,
  input  logic [7:0] wdata0,
  input  logic [7:0] wdata1,
  output logic       done0,
  output logic       done1,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       gnt_id,
  output logic [2:0] state_dbg,
  output logic       CS,
  output logic       RD,
  output logic       WR,
  output logic       A_D,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  input  logic [7:0] ad_in
);

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StAdr  = 3'd1,
    StAdrH = 3'd2,
    StDat  = 3'd3,
    StDatH = 3'd4,
    StRec  = 3'd5
  } state_e;

  localparam logic [7:0] PulseLoad = 8'(PULSE_CYC - 1);
  localparam logic [7:0] GapLoad   = 8'(GAP_CYC - 1);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       gnt_q, gnt_d;
  logic       rw_q, rw_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic [7:0] rdata_q, rdata_d;
  logic       done0_q, done0_d, done1_q, done1_d;
  logic       cs_q, cs_d, rd_q, rd_d, wr_q, wr_d, ad_q, ad_d, oe_q, oe_d;
  logic [7:0] adout_q, adout_d;
  logic       pick;
`ifdef RTC_ARB_RR_EN
  logic       rr_q, rr_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
`ifdef RTC_ARB_RR_EN
    rr_d = rr_q;
    pick = (req0 && req1) ? rr_q : req1;
`else
    pick = ~req0;
`endif

    unique case (state_q)
      StIdle: begin
        if (req0 || req1) begin
          gnt_d   = pick;
          rw_d    = pick ? rw1 : rw0;
          addr_d  = pick ? addr1 : addr0;
          wdata_d = pick ? wdata1 : wdata0;
          state_d = StAdr;
`ifdef RTC_ARB_RR_EN
          rr_d = ~pick;
`endif
        end
      end
      StAdr:   if (cnt_q == 8'd0) state_d = StAdrH;
      StAdrH:  if (cnt_q == 8'd0) state_d = StDat;
      StDat:   if (cnt_q == 8'd0) state_d = StDatH;
      StDatH:  if (cnt_q == 8'd0) state_d = StRec;
      StRec:   if (cnt_q == 8'd0) state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (state_d != state_q) begin
      unique case (state_d)
        StAdr, StDat:         cnt_d = PulseLoad;
        StAdrH, StDatH, StRec: cnt_d = GapLoad;
        default:              cnt_d = 8'd0;
      endcase
    end else if (cnt_q != 8'd0) begin
      cnt_d = cnt_q - 8'd1;
    end

    // Sample the pad at the end of the final RD-low cycle.
    if (state_q == StDat && cnt_q == 8'd0 && rw_q) rdata_d = ad_in;

    done0_d = (state_q == StDatH) && (state_d == StRec) && !gnt_q;
    done1_d = (state_q == StDatH) && (state_d == StRec) && gnt_q;

    // Pins are decoded from the next state so they leave the flops glitch-free.
    cs_d    = 1'b1;
    rd_d    = 1'b1;
    wr_d    = 1'b1;
    ad_d    = 1'b1;
    oe_d    = 1'b0;
    adout_d = 8'h00;
    unique case (state_d)
      StAdr: begin
        cs_d = 1'b0; ad_d = 1'b0; wr_d = 1'b0; oe_d = 1'b1; adout_d = addr_d;
      end
      StAdrH: begin
        cs_d = 1'b0; ad_d = 1'b0; oe_d = 1'b1; adout_d = addr_d;
      end
      StDat: begin
        cs_d = 1'b0;
        if (rw_d) begin
          rd_d = 1'b0;
        end else begin
          wr_d = 1'b0; oe_d = 1'b1; adout_d = wdata_d;
        end
      end
      StDatH: begin
        cs_d    = 1'b0;
        oe_d    = ~rw_d;
        adout_d = rw_d ? 8'h00 : wdata_d;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= StIdle;
      cnt_q   <= 8'd0;
      gnt_q   <= 1'b0;
      rw_q    <= 1'b0;
      addr_q  <= 8'h00;
      wdata_q <= 8'h00;
      rdata_q <= 8'h00;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      cs_q    <= 1'b1;
      rd_q    <= 1'b1;
      wr_q    <= 1'b1;
      ad_q    <= 1'b1;
      oe_q    <= 1'b0;
      adout_q <= 8'h00;
`ifdef RTC_ARB_RR_EN
      rr_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
      cs_q    <= cs_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      ad_q    <= ad_d;
      oe_q    <= oe_d;
      adout_q <= adout_d;
`ifdef RTC_ARB_RR_EN
      rr_q    <= rr_d;
`endif
    end
  end

  assign done0     = done0_q;
  assign done1     = done1_q;
  assign rdata     = rdata_q;
  assign busy      = (state_q != StIdle);
  assign gnt_id    = gnt_q;
  assign state_dbg = state_q;
  assign CS        = cs_q;
  assign RD        = rd_q;
  assign WR        = wr_q;
  assign A_D       = ad_q;
  assign ad_out    = adout_q;
  assign ad_oe     = oe_q;

endmodule
